flexbex_ibex_multdiv_slow: RTL and testbench
============================================

FLEXBEX_IBEX_MULTDIV_SLOW -- requirements
Module: flexbex_ibex_multdiv_slow

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port multdiv_en_i, input, 1, request level, held by the decoder until ready_o.
REQ-004 SHALL have port operator_i, input, 3, operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have ports op_a_i and op_b_i, input, 32 each, source operands rs1 and rs2.
REQ-006 SHALL have port alu_adder_ext_i, input, 34, the shared ALU extended adder sum.
REQ-007 SHALL have ports alu_operand_a_o and alu_operand_b_o, output, 33 each, shared ALU adder operands.
REQ-008 SHALL have port alu_en_o, output, 1, selects the block's operands into the shared ALU adder.
REQ-009 SHALL have port busy_o, output, 1, high when state is not IDLE.
REQ-010 SHALL have port ready_o, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port result_o, output, 32, result, valid only while ready_o is high.

Function
REQ-012 SHALL use FSM states IDLE, ABS_A, ABS_B, COMP, LAST, CHANGE_SIGN, FINISH.
REQ-013 SHALL start an operation only in IDLE with multdiv_en_i=1; operands and operator latched that cycle (cycle N); later input changes ignored.
REQ-014 SHALL follow path IDLE->COMP(32 cycles)->LAST->FINISH for MUL ops, ready_o high in cycle N+34.
REQ-015 SHALL follow path IDLE->ABS_A->ABS_B->COMP(32)->LAST->CHANGE_SIGN->FINISH for DIV ops, ready_o high in cycle N+37.
REQ-016 SHALL use a 5-bit iteration counter loaded 31 on COMP entry, decremented each COMP cycle, with COMP->LAST on count 0.
REQ-017 SHALL perform every add/subtract through the shared adder: sum = alu_adder_ext_i[33:1]; A+B as {A,1}+{B,0}; A-B as {A,1}+{~B,1}.
REQ-018 SHALL hold alu_en_o=1 in ABS_A, ABS_B, COMP, LAST and CHANGE_SIGN, and 0 otherwise.
REQ-019 SHALL compute MUL as product[31:0] and MULH/MULHSU/MULHU as product[63:32], sign-extending to 33 bits for signed operands (MULH both, MULHSU op_a only).
REQ-020 SHALL perform restoring division on magnitudes for DIV/REM, using ABS_A/ABS_B to negate negative signed operands; DIVU/REMU pass through unchanged.
REQ-021 SHALL negate in CHANGE_SIGN: quotient when operand signs differ (DIV), remainder when dividend negative (REM).
REQ-022 SHALL return on divide by zero: DIV/DIVU 0xFFFFFFFF, REM/REMU = op_a; no trap, same latency.
REQ-023 SHALL return on DIV overflow (0x80000000 / 0xFFFFFFFF) quotient 0x80000000, REM remainder 0.
REQ-024 SHALL return to IDLE from FINISH; a multdiv_en_i still high in the cycle after ready_o starts a new operation.
REQ-025 SHALL go to IDLE on the next edge, without asserting ready_o, when multdiv_en_i drops in any non-IDLE state (kill/flush).
REQ-026 SHALL drive result_o = 0 whenever ready_o = 0.

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE, counter 0, all operand/accumulator registers 0, ready_o 0, busy_o 0, alu_en_o 0, result_o 0.
REQ-028 SHALL discard an operation interrupted by reset; the first request after release starts cleanly at cycle N.

Structure
REQ-029 SHALL take the md_op (3-bit operator) and md_state enumerations from the shared flexbex_ibex_pkg.
REQ-030 SHALL be a single module with no sub-module; the shared adder stays external in the ALU.

Verification
REQ-031 SHALL verify MULH: a=0x80000000, b=0x80000000 -> ready_o at N+34, result 0x40000000.
REQ-032 SHALL verify MULHSU: a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFF; MUL same operands -> 0x00000001.
REQ-033 SHALL verify DIV: a=-7 (0xFFFFFFF9), b=2 -> ready_o at N+37, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-034 SHALL verify DIVU: b=0, a=0x1234 -> 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-035 SHALL verify kill: multdiv_en_i dropped at N+10 -> IDLE at N+11, no ready_o; new request at N+12 completes normally.
REQ-036 SHALL verify reset: rst_n low mid-COMP -> all outputs 0 immediately; back-to-back requests each produce exactly one ready_o.

Source files
------------

// File: rtl/flexbex_ibex_pkg.sv
// Shared flexbex_ibex types: multiplier/divider operator codes and FSM states.
package flexbex_ibex_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE        = 3'd0,
    MD_ABS_A       = 3'd1,
    MD_ABS_B       = 3'd2,
    MD_COMP        = 3'd3,
    MD_LAST        = 3'd4,
    MD_CHANGE_SIGN = 3'd5,
    MD_FINISH      = 3'd6
  } md_state_e;

  localparam logic [4:0] MD_ITER_LAST = 5'd31;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/flexbex_ibex_multdiv_slow.sv
// Iterative 32-bit multiplier/divider; one bit per cycle through the ALU's shared extended adder.
module flexbex_ibex_multdiv_slow
  import flexbex_ibex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        multdiv_en_i,
  input  logic [2:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        alu_en_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o
);

  md_state_e   state_q;
  md_op_e      op_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] result_q;
  logic        neg_q;

  logic [32:0] sum;
  logic        unused_adder_lsb;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] rem_shift;
  logic        take;
  logic        add_ext;
  logic        t_msb;
  logic        neg_start;

  assign sum              = alu_adder_ext_i[33:1];
  assign unused_adder_lsb = alu_adder_ext_i[0];
  assign is_div           = md_is_div(op_q);
  assign sign_a           = (op_q == MD_OP_MULH) || (op_q == MD_OP_MULHSU);
  assign sign_b           = (op_q == MD_OP_MULH);
  assign rem_shift        = {hi_q[30:0], lo_q[31]};
  // Shifted remainder overflowing 32 bits always exceeds the divisor.
  assign take             = hi_q[31] | sum[32];
  // Bit 32 of the sign-extended 33-bit partial sum, rebuilt from the 32-bit carry.
  assign t_msb            = (sign_a & hi_q[31]) ^ add_ext ^ sum[32];

  assign neg_start = (operator_i == MD_OP_DIV) ? ((op_a_i[31] ^ op_b_i[31]) & (op_b_i != 32'd0)) :
                     (operator_i == MD_OP_REM) ? op_a_i[31] : 1'b0;

  assign busy_o   = (state_q != MD_IDLE);
  assign ready_o  = (state_q == MD_FINISH);
  assign result_o = ready_o ? result_q : 32'd0;
  assign alu_en_o = (state_q == MD_ABS_A) || (state_q == MD_ABS_B) || (state_q == MD_COMP) ||
                    (state_q == MD_LAST)  || (state_q == MD_CHANGE_SIGN);

  // Shared adder operand selection: negations, add/sub steps and trial subtraction.
  always_comb begin
    alu_operand_a_o = 33'd0;
    alu_operand_b_o = 33'd0;
    add_ext         = 1'b0;
    case (state_q)
      MD_ABS_A: begin
        alu_operand_a_o = {32'd0, 1'b1};
        alu_operand_b_o = {~lo_q, 1'b1};
      end
      MD_ABS_B: begin
        alu_operand_a_o = {32'd0, 1'b1};
        alu_operand_b_o = {~b_q, 1'b1};
      end
      MD_COMP: begin
        if (is_div) begin
          alu_operand_a_o = {rem_shift, 1'b1};
          alu_operand_b_o = {~b_q, 1'b1};
        end else begin
          alu_operand_a_o = {hi_q, 1'b1};
          if (lo_q[0]) begin
            if ((cnt_q == 5'd0) && sign_b) begin
              alu_operand_b_o = {~a_q, 1'b1};
              add_ext         = ~a_q[31];
            end else begin
              alu_operand_b_o = {a_q, 1'b0};
              add_ext         = sign_a & a_q[31];
            end
          end else begin
            alu_operand_b_o = 33'd0;
          end
        end
      end
      MD_CHANGE_SIGN: begin
        alu_operand_a_o = {32'd0, 1'b1};
        alu_operand_b_o = {~result_q, 1'b1};
      end
      default: begin
        alu_operand_a_o = 33'd0;
        alu_operand_b_o = 33'd0;
      end
    endcase
  end

  // Control FSM and datapath registers; a dropped request kills any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_OP_MUL;
      cnt_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      neg_q    <= 1'b0;
    end else if ((state_q != MD_IDLE) && !multdiv_en_i) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (multdiv_en_i) begin
            op_q  <= md_op_e'(operator_i);
            a_q   <= op_a_i;
            b_q   <= op_b_i;
            hi_q  <= 32'd0;
            lo_q  <= md_is_div(operator_i) ? op_a_i : op_b_i;
            neg_q <= neg_start;
            if (md_is_div(operator_i)) begin
              state_q <= MD_ABS_A;
            end else begin
              state_q <= MD_COMP;
              cnt_q   <= MD_ITER_LAST;
            end
          end
        end
        MD_ABS_A: begin
          if (!op_q[0] && a_q[31]) begin
            lo_q <= sum[31:0];
          end
          state_q <= MD_ABS_B;
        end
        MD_ABS_B: begin
          if (!op_q[0] && b_q[31]) begin
            b_q <= sum[31:0];
          end
          cnt_q   <= MD_ITER_LAST;
          state_q <= MD_COMP;
        end
        MD_COMP: begin
          if (is_div) begin
            hi_q <= take ? sum[31:0] : rem_shift;
            lo_q <= {lo_q[30:0], take};
          end else begin
            hi_q <= {t_msb, sum[31:1]};
            lo_q <= {sum[0], lo_q[31:1]};
          end
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q <= MD_LAST;
          end
        end
        MD_LAST: begin
          // MUL and DIV/DIVU take the low word; high products and remainders the high word.
          if ((op_q == MD_OP_MUL) || (op_q == MD_OP_DIV) || (op_q == MD_OP_DIVU)) begin
            result_q <= lo_q;
          end else begin
            result_q <= hi_q;
          end
          state_q <= is_div ? MD_CHANGE_SIGN : MD_FINISH;
        end
        MD_CHANGE_SIGN: begin
          if (neg_q) begin
            result_q <= sum[31:0];
          end
          state_q <= MD_FINISH;
        end
        MD_FINISH: begin
          state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flexbex_ibex_multdiv_slow.sv
// Directed bench for flexbex_ibex_multdiv_slow; the bench plays the ALU's extended adder.
module tb_flexbex_ibex_multdiv_slow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        multdiv_en_i;
  logic [2:0]  operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [33:0] alu_adder_ext_i;
  logic [32:0] alu_operand_a_o;
  logic [32:0] alu_operand_b_o;
  logic        alu_en_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

  flexbex_ibex_multdiv_slow dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .multdiv_en_i   (multdiv_en_i),
    .operator_i     (operator_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .alu_adder_ext_i(alu_adder_ext_i),
    .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o),
    .alu_en_o       (alu_en_o),
    .busy_o         (busy_o),
    .ready_o        (ready_o),
    .result_o       (result_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request held until ready_o; inputs are scrambled after the start cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          lat = 0;
    logic [31:0] res = 32'd0;
    @(negedge clk);
    multdiv_en_i = 1'b1;
    operator_i   = op;
    op_a_i       = a;
    op_b_i       = b;
    for (int k = 1; k <= 45 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      op_a_i     = $urandom;
      op_b_i     = $urandom;
      operator_i = 3'($urandom_range(7, 0));
      @(negedge clk);
      if (k == 5) begin
        check({tag, " mid busy/alu_en/ready/result"}, {busy_o, alu_en_o, ready_o, result_o},
              {1'b1, 1'b1, 1'b0, 32'd0});
      end
      if (ready_o) begin
        lat = k;
        res = result_o;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, res, exp_res);
    multdiv_en_i = 1'b0;
    @(negedge clk);
    check({tag, " back to idle"}, {busy_o, ready_o, alu_en_o, result_o}, 35'd0);
  endtask

  initial begin
    int saw_ready;
    int pulses;
    int first_lat;
    int second_lat;
    rst_n        = 1'b0;
    multdiv_en_i = 1'b0;
    operator_i   = 3'd0;
    op_a_i       = 32'd0;
    op_b_i       = 32'd0;
    #3;
    check("reset outputs", {busy_o, ready_o, alu_en_o, result_o}, 35'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("MULH min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHSU -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("MUL -1*-1",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run_op("MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("MULH -2*3",      3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34);
    run_op("MUL 3*5",        3'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 34);
    run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 37);
    run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 37);
    run_op("DIVU x/0",       3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 37);
    run_op("REMU x/0",       3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 37);
    run_op("DIV overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 37);
    run_op("REM overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 37);
    run_op("DIV -7/0",       3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 37);
    run_op("REM -7/0",       3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 37);
    run_op("DIVU 100/7",     3'd5, 32'd100,        32'd7,         32'd14,        37);
    run_op("REMU 100/7",     3'd7, 32'd100,        32'd7,         32'd2,         37);
    run_op("DIV 100/-7",     3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 37);

    // Kill: request dropped in cycle N+10, idle in N+11, fresh request in N+12.
    saw_ready = 0;
    @(negedge clk);
    multdiv_en_i = 1'b1;
    operator_i   = 3'd0;
    op_a_i       = 32'd7;
    op_b_i       = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready_o) saw_ready++;
    end
    multdiv_en_i = 1'b0;
    @(negedge clk);
    if (ready_o) saw_ready++;
    check("kill idle next cycle", {busy_o, alu_en_o, ready_o}, 3'b000);
    check("kill no ready", 64'(saw_ready), 64'd0);
    run_op("MUL after kill", 3'd0, 32'd7, 32'd9, 32'd63, 34);

    // Reset in the middle of COMP of a division.
    @(negedge clk);
    multdiv_en_i = 1'b1;
    operator_i   = 3'd4;
    op_a_i       = 32'd1000;
    op_b_i       = 32'd3;
    repeat (15) @(negedge clk);
    check("busy before reset", {busy_o, alu_en_o}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-COMP outputs", {busy_o, ready_o, alu_en_o, result_o}, 35'd0);
    check("reset mid-COMP operands", {alu_operand_a_o, alu_operand_b_o}, 66'd0);
    multdiv_en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: request held high across two operations.
    pulses     = 0;
    first_lat  = 0;
    second_lat = 0;
    @(negedge clk);
    multdiv_en_i = 1'b1;
    operator_i   = 3'd0;
    op_a_i       = 32'd3;
    op_b_i       = 32'd5;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (pulses == 1) first_lat = k;
        if (pulses == 2) begin
          second_lat   = k;
          multdiv_en_i = 1'b0;
        end
        check("back-to-back result", result_o, 32'd15);
      end
    end
    check("back-to-back pulses", 64'(pulses), 64'd2);
    check("back-to-back first latency", 64'(first_lat), 64'd34);
    check("back-to-back second latency", 64'(second_lat), 64'd69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
